// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch sequencer
package fetch_pkg;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_TRAP} fetch_state_t;
  localparam int PC_STEP = 4;
  localparam logic [3:0] WB_SEL_WORD = 4'hF;
endpackage

// File: rtl/pc_next_sel.sv
// pc_next_sel: next-PC selection among pc+4, redirect target and the pending redirect
// Ports: pc, redirect_valid, redirect_target, pending, use_pending in; target (alignment-handled
// redirect target) and pc_next out; misalign out only when PC_MISALIGN_TRAP_EN is defined.
// Without PC_MISALIGN_TRAP_EN the redirect target is forced to word alignment.
module pc_next_sel import fetch_pkg::*; #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_target,
  input  logic [ADDR_WIDTH-1:0] pending,
  input  logic                  use_pending,
  output logic [ADDR_WIDTH-1:0] target,
`ifdef PC_MISALIGN_TRAP_EN
  output logic                  misalign,
`endif
  output logic [ADDR_WIDTH-1:0] pc_next
);
  always_comb begin
`ifdef PC_MISALIGN_TRAP_EN
    target = redirect_target;
`else
    target = redirect_target & ~ADDR_WIDTH'(3);
`endif
    pc_next = redirect_valid ? target : use_pending ? pending : pc + ADDR_WIDTH'(PC_STEP);
`ifdef PC_MISALIGN_TRAP_EN
    misalign = |pc_next[1:0];
`endif
  end
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: RV32 instruction-fetch sequencer owning the PC, with a Wishbone-classic read master
// Ports: clk, reset (sync, active-low); redirect_valid/redirect_target from next-PC datapath;
// wb_cyc_o/wb_stb_o/wb_we_o/wb_sel_o/wb_adr_o/wb_dat_i/wb_ack_i instruction bus;
// if_valid/if_ready/if_pc/if_instr/if_exc decode handshake.
// Optional PC_MISALIGN_TRAP_EN: misaligned redirect targets present a fetch exception instead of a bus read.
module fetch_ctrl import fetch_pkg::*; #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] PC_ADDR = 32'h8000_0000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    redirect_valid,
  input  logic [ADDR_WIDTH-1:0]   redirect_target,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic                    wb_ack_i,
  output logic                    if_valid,
  input  logic                    if_ready,
  output logic [ADDR_WIDTH-1:0]   if_pc,
  output logic [DATA_WIDTH-1:0]   if_instr,
  output logic                    if_exc
);
  fetch_state_t state;
  logic [ADDR_WIDTH-1:0] pc, pending, target, pc_next;
  logic [DATA_WIDTH-1:0] instr;
  logic kill, cyc, valid, trap;
  pc_next_sel #(.ADDR_WIDTH(ADDR_WIDTH)) u_sel (
    .pc(pc),
    .redirect_valid(redirect_valid),
    .redirect_target(redirect_target),
    .pending(pending),
    .use_pending(kill),
    .target(target),
`ifdef PC_MISALIGN_TRAP_EN
    .misalign(trap),
`endif
    .pc_next(pc_next)
  );
`ifdef PC_MISALIGN_TRAP_EN
  assign if_exc = valid && state == S_TRAP;
`else
  assign trap = 1'b0;
  assign if_exc = 1'b0;
`endif
  assign wb_cyc_o = cyc;
  assign wb_stb_o = cyc;
  assign wb_we_o = 1'b0;
  assign wb_sel_o = (DATA_WIDTH/8)'(WB_SEL_WORD);
  assign wb_adr_o = pc;
  assign if_valid = valid;
  assign if_pc = pc;
  assign if_instr = instr;
  // A "launch" loads pc_next and either starts a bus read or, for a misaligned target, presents a trap entry.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      pc <= PC_ADDR;
      kill <= 1'b0;
      pending <= '0;
      cyc <= 1'b0;
      valid <= 1'b0;
      instr <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          pc <= redirect_valid ? pc_next : pc;
          state <= trap ? S_TRAP : S_REQ;
          cyc <= !trap;
          valid <= trap;
        end
        S_REQ: begin
          if (wb_ack_i && (kill || redirect_valid)) begin
            pc <= pc_next;
            kill <= 1'b0;
            state <= trap ? S_TRAP : S_REQ;
            cyc <= !trap;
            valid <= trap;
            instr <= '0;
          end else if (wb_ack_i) begin
            instr <= wb_dat_i;
            valid <= 1'b1;
            cyc <= 1'b0;
            state <= S_HOLD;
          end else if (redirect_valid) begin
            kill <= 1'b1;
            pending <= target;
          end
        end
        S_HOLD: begin
          if (redirect_valid || if_ready) begin
            pc <= pc_next;
            state <= trap ? S_TRAP : S_REQ;
            cyc <= !trap;
            valid <= trap;
            instr <= '0;
          end
        end
`ifdef PC_MISALIGN_TRAP_EN
        S_TRAP: begin
          if (redirect_valid) begin
            pc <= pc_next;
            state <= trap ? S_TRAP : S_REQ;
            cyc <= !trap;
            valid <= trap;
            instr <= '0;
          end else if (if_ready) begin
            valid <= 1'b0;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: self-checking bench for fetch_ctrl with a Wishbone slave and a transaction-level PC model
module tb_fetch_ctrl;
  localparam logic [31:0] PC0 = 32'h8000_0000;
  logic clk = 1'b0, reset = 1'b0, redirect_valid = 1'b0, if_ready = 1'b0, wb_ack_i = 1'b0;
  logic [31:0] redirect_target = '0, wb_dat_i = '0;
  logic wb_cyc_o, wb_stb_o, wb_we_o, if_valid, if_exc;
  logic [3:0] wb_sel_o;
  logic [31:0] wb_adr_o, if_pc, if_instr;
  int n_assert = 0, n_fail = 0, n_acc = 0, nwait = 1, cnt = 1;
  logic [31:0] exp_pc = PC0, p_adr = '0, s_pc, s_instr;
  logic p_stb = 1'b0, p_ack = 1'b0;

  fetch_ctrl dut (
    .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
    .wb_adr_o(wb_adr_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr), .if_exc(if_exc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] tgt(input logic [31:0] t);
`ifdef PC_MISALIGN_TRAP_EN
    return t;
`else
    return t & 32'hFFFF_FFFC;
`endif
  endfunction

  function automatic logic exp_exc(input logic [31:0] p);
`ifdef PC_MISALIGN_TRAP_EN
    return |p[1:0];
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: the accepted PC stream is sequential by 4, restarting at the last redirect target.
  task automatic tick();
    if (!reset) exp_pc = PC0;
    else begin
      if (if_valid) begin
        chk("exc", {31'b0, if_exc}, {31'b0, exp_exc(if_pc)});
        chk("instr", if_instr, exp_exc(if_pc) ? 32'h0 : mem(if_pc));
      end
      if (if_valid && if_ready && !redirect_valid) begin
        chk("accept_pc", if_pc, exp_pc);
        exp_pc += 4;
        n_acc++;
      end
      if (redirect_valid) exp_pc = tgt(redirect_target);
    end
    @(posedge clk);
    #1;
    if (wb_stb_o && p_stb && !p_ack) chk("adr_stable", wb_adr_o, p_adr);
    p_stb = wb_stb_o;
    p_adr = wb_adr_o;
    if (wb_ack_i) begin
      wb_ack_i = 1'b0;
      cnt = nwait;
    end else if (wb_cyc_o && wb_stb_o) begin
      if (cnt == 0) begin
        wb_ack_i = 1'b1;
        wb_dat_i = mem(wb_adr_o);
      end else cnt--;
    end
    p_ack = wb_ack_i;
  endtask

  task automatic wait_ack();
    for (int n = 0; n < 50 && !wb_ack_i; n++) tick();
    chk("ack_seen", {31'b0, wb_ack_i}, 32'd1);
  endtask

  initial begin
    tick();
    tick();
    chk("rst_cyc", {31'b0, wb_cyc_o}, 0);
    chk("rst_stb", {31'b0, wb_stb_o}, 0);
    chk("rst_valid", {31'b0, if_valid}, 0);
    chk("rst_exc", {31'b0, if_exc}, 0);
    chk("rst_instr", if_instr, 0);
    chk("we", {31'b0, wb_we_o}, 0);
    chk("sel", {28'b0, wb_sel_o}, 32'hF);
    reset = 1'b1;
    if_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_ack();
      chk("seq_adr", wb_adr_o, PC0 + 32'(4 * k));
      tick();
      chk("ack_to_valid", {31'b0, if_valid}, 1);
      chk("seq_pc", if_pc, PC0 + 32'(4 * k));
      chk("seq_instr", if_instr, mem(PC0 + 32'(4 * k)));
      tick();
      chk("hs_to_stb", {31'b0, wb_stb_o}, 1);
    end
    if_ready = 1'b0;
    wait_ack();
    tick();
    s_pc = if_pc;
    s_instr = if_instr;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_valid", {31'b0, if_valid}, 1);
      chk("bp_pc", if_pc, s_pc);
      chk("bp_instr", if_instr, s_instr);
      chk("bp_stb", {31'b0, wb_stb_o}, 0);
    end
    if_ready = 1'b1;
    tick();
    chk("bp_release_stb", {31'b0, wb_stb_o}, 1);
    cnt = 3;
    tick();
    redirect_valid = 1'b1;
    redirect_target = 32'h8000_0100;
    tick();
    redirect_valid = 1'b0;
    wait_ack();
    tick();
    chk("kill_valid", {31'b0, if_valid}, 0);
    chk("kill_stb", {31'b0, wb_stb_o}, 1);
    chk("kill_adr", wb_adr_o, 32'h8000_0100);
    if_ready = 1'b0;
    wait_ack();
    tick();
    chk("kill_next_pc", if_pc, 32'h8000_0100);
    redirect_valid = 1'b1;
    redirect_target = 32'h8000_0040;
    if_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    chk("redir_hs_stb", {31'b0, wb_stb_o}, 1);
    chk("redir_hs_adr", wb_adr_o, 32'h8000_0040);
    chk("redir_hs_valid", {31'b0, if_valid}, 0);
    cnt = 2;
    reset = 1'b0;
    tick();
    chk("mid_rst_cyc", {31'b0, wb_cyc_o}, 0);
    chk("mid_rst_stb", {31'b0, wb_stb_o}, 0);
    chk("mid_rst_valid", {31'b0, if_valid}, 0);
    reset = 1'b1;
    wb_ack_i = 1'b1;
    wb_dat_i = 32'hDEAD_BEEF;
    if_ready = 1'b0;
    tick();
    chk("late_ack_valid", {31'b0, if_valid}, 0);
    chk("post_rst_adr", wb_adr_o, PC0);
    wait_ack();
    tick();
    chk("post_rst_pc", if_pc, PC0);
    redirect_valid = 1'b1;
    redirect_target = 32'h8000_0102;
    tick();
    redirect_valid = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
    chk("trap_stb", {31'b0, wb_stb_o}, 0);
    chk("trap_valid", {31'b0, if_valid}, 1);
    chk("trap_exc", {31'b0, if_exc}, 1);
    chk("trap_pc", if_pc, 32'h8000_0102);
    chk("trap_instr", if_instr, 0);
    if_ready = 1'b1;
    tick();
    chk("trap_done_valid", {31'b0, if_valid}, 0);
    tick();
    chk("trap_idle_stb", {31'b0, wb_stb_o}, 0);
    redirect_valid = 1'b1;
    redirect_target = 32'h8000_0200;
    tick();
    redirect_valid = 1'b0;
    chk("trap_exit_adr", wb_adr_o, 32'h8000_0200);
`else
    chk("mask_stb", {31'b0, wb_stb_o}, 1);
    chk("mask_adr", wb_adr_o, 32'h8000_0100);
`endif
    if_ready = 1'b0;
    wait_ack();
    tick();
    redirect_valid = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    wait_ack();
    tick();
    chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
    if_ready = 1'b1;
    tick();
    chk("wrap_adr", wb_adr_o, 32'h0);
    for (int i = 0; i < 3000; i++) begin
      if_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_target = {16'h8000, 4'h0, 10'($urandom_range(0, 1023)),
                         ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00};
      nwait = $urandom_range(0, 3);
      tick();
    end
    redirect_valid = 1'b0;
    chk("enough_accepts", {31'b0, n_acc > 100}, 1);
    chk("we_end", {31'b0, wb_we_o}, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
